// File: rtl/axis_frame_pkg.sv
// Shared definitions for the receive-path frame length filter and its stream helpers.
package axis_frame_pkg;

  typedef enum logic [0:0] {
    PASS = 1'b0,
    DROP = 1'b1
  } filt_state_t;

  // tuser bit consumed by the frame FIFO wrapper as its bad-frame input
  localparam int FLAG_BAD_BIT    = 0;
  localparam int AXIS_ID_WIDTH   = 8;
  localparam int AXIS_DEST_WIDTH = 8;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    if (value == 32'hFFFF_FFFF) begin
      sat_inc32 = value;
    end else begin
      sat_inc32 = value + 32'd1;
    end
  endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-Stream interface bundle with master/slave modports.
interface AXIS_IF #(
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  localparam int KEEP_WIDTH = (DATA_WIDTH + 7) / 8;

  logic                                      tvalid;
  logic                                      tready;
  logic [DATA_WIDTH-1:0]                     tdata;
  logic [KEEP_WIDTH-1:0]                     tkeep;
  logic                                      tlast;
  logic [axis_frame_pkg::AXIS_ID_WIDTH-1:0]   tid;
  logic [axis_frame_pkg::AXIS_DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0]                     tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tid, tdest, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry register slice: registered ready upstream, registered valid/data downstream.
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_valid_r;
  logic [WIDTH-1:0] main_data_r;
  logic             skid_valid_r;
  logic [WIDTH-1:0] skid_data_r;
  logic             push_s;

  // Ready only reflects skid occupancy, so it never sees out_ready combinationally.
  assign in_ready  = ~skid_valid_r & ~reset;
  assign push_s    = in_valid & in_ready;
  assign out_valid = main_valid_r;
  assign out_data  = main_data_r;

  // Main register refills from the skid entry first, otherwise straight from the input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_r <= 1'b0;
      main_data_r  <= {WIDTH{1'b0}};
      skid_valid_r <= 1'b0;
      skid_data_r  <= {WIDTH{1'b0}};
    end else if (!main_valid_r || out_ready) begin
      if (skid_valid_r) begin
        main_valid_r <= 1'b1;
        main_data_r  <= skid_data_r;
        skid_valid_r <= 1'b0;
      end else begin
        main_valid_r <= push_s;
        if (push_s) begin
          main_data_r <= in_data;
        end
      end
    end else if (push_s) begin
      skid_valid_r <= 1'b1;
      skid_data_r  <= in_data;
    end
  end

endmodule

// File: rtl/axis_frame_len_filter.sv
// Flags runt/oversize frames on tuser[0] and truncates oversize frames at MAX_LEN beats.
// Optional statistics counters: define AXIS_FRAME_LEN_FILTER_STATS_EN.
module axis_frame_len_filter
  import axis_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int MIN_LEN    = 64,
  parameter int MAX_LEN    = 1518
) (
  input  logic        clk,
  input  logic        reset,
  AXIS_IF.slave       in_axis_if,
  AXIS_IF.master      out_axis_if,
  output logic        status_runt,
  output logic        status_oversize,
  output logic        status_good
`ifdef AXIS_FRAME_LEN_FILTER_STATS_EN
  ,
  output logic [31:0] stat_frames,
  output logic [31:0] stat_bad
`endif
);

  localparam int LEN_WIDTH  = $clog2(MAX_LEN + 1);
  localparam int KEEP_WIDTH = (DATA_WIDTH + 7) / 8;
  localparam int WORD_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1 + AXIS_ID_WIDTH + AXIS_DEST_WIDTH + USER_WIDTH;

  filt_state_t           state_r;
  filt_state_t           state_s;
  logic [LEN_WIDTH-1:0]  cnt_r;
  logic [LEN_WIDTH-1:0]  cnt_s;
  logic [LEN_WIDTH-1:0]  cnt_inc_s;
  logic                  in_ready_s;
  logic                  skid_ready_s;
  logic                  accept_s;
  logic                  fwd_valid_s;
  logic                  fwd_last_s;
  logic                  flag_s;
  logic                  runt_s;
  logic                  over_s;
  logic                  good_s;
  logic [USER_WIDTH-1:0] fwd_user_s;
  logic [WORD_WIDTH-1:0] fwd_word_s;
  logic [WORD_WIDTH-1:0] out_word_s;

  // DROP swallows the tail of a truncated frame regardless of downstream backpressure.
  assign in_ready_s        = (state_r == DROP) ? 1'b1 : skid_ready_s;
  assign in_axis_if.tready = in_ready_s;
  assign accept_s          = in_axis_if.tvalid & in_ready_s;
  assign cnt_inc_s         = cnt_r + LEN_WIDTH'(1);

  // Frame length decision for the beat accepted this cycle.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    fwd_valid_s = 1'b0;
    fwd_last_s  = in_axis_if.tlast;
    flag_s      = 1'b0;
    runt_s      = 1'b0;
    over_s      = 1'b0;
    good_s      = 1'b0;
    case (state_r)
      PASS: begin
        if (accept_s) begin
          fwd_valid_s = 1'b1;
          if (in_axis_if.tlast) begin
            cnt_s = {LEN_WIDTH{1'b0}};
            if (cnt_inc_s < LEN_WIDTH'(MIN_LEN)) begin
              flag_s = 1'b1;
              runt_s = 1'b1;
            end else begin
              good_s = 1'b1;
            end
          end else if (cnt_inc_s == LEN_WIDTH'(MAX_LEN)) begin
            fwd_last_s = 1'b1;
            flag_s     = 1'b1;
            over_s     = 1'b1;
            cnt_s      = {LEN_WIDTH{1'b0}};
            state_s    = DROP;
          end else begin
            cnt_s = cnt_inc_s;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      DROP: begin
        if (accept_s && in_axis_if.tlast) begin
          state_s = PASS;
        end else begin
          state_s = DROP;
        end
      end
      default: begin
        state_s = PASS;
        cnt_s   = {LEN_WIDTH{1'b0}};
      end
    endcase
  end

  // Merge the local bad flag into the incoming user bits.
  always_comb begin
    fwd_user_s               = in_axis_if.tuser;
    fwd_user_s[FLAG_BAD_BIT] = in_axis_if.tuser[FLAG_BAD_BIT] | flag_s;
  end

  assign fwd_word_s = {in_axis_if.tdata, in_axis_if.tkeep, fwd_last_s,
                       in_axis_if.tid, in_axis_if.tdest, fwd_user_s};

  axis_skid_buffer #(
    .WIDTH(WORD_WIDTH)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_valid (fwd_valid_s),
    .in_ready (skid_ready_s),
    .in_data  (fwd_word_s),
    .out_valid(out_axis_if.tvalid),
    .out_ready(out_axis_if.tready),
    .out_data (out_word_s)
  );

  assign {out_axis_if.tdata, out_axis_if.tkeep, out_axis_if.tlast,
          out_axis_if.tid, out_axis_if.tdest, out_axis_if.tuser} = out_word_s;

  // Filter state, beat counter and registered status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r         <= PASS;
      cnt_r           <= {LEN_WIDTH{1'b0}};
      status_runt     <= 1'b0;
      status_oversize <= 1'b0;
      status_good     <= 1'b0;
    end else begin
      state_r         <= state_s;
      cnt_r           <= cnt_s;
      status_runt     <= runt_s;
      status_oversize <= over_s;
      status_good     <= good_s;
    end
  end

`ifdef AXIS_FRAME_LEN_FILTER_STATS_EN
  // Saturating frame and bad-frame counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_frames <= 32'd0;
      stat_bad    <= 32'd0;
    end else begin
      if (runt_s || over_s || good_s) begin
        stat_frames <= sat_inc32(stat_frames);
      end
      if (runt_s || over_s) begin
        stat_bad <= sat_inc32(stat_bad);
      end
    end
  end
`endif

endmodule
